// File: rtl/w0rm_stream_scoreboard.sv
// Stream scoreboard: queues expected beats (masked) and compares each observed beat against the head.
// Compare results reach the counters one cycle after the observed beat; exp_ready drops when full or after finish.
module w0rm_stream_scoreboard #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = 16,
  parameter int TIMEOUT    = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  exp_valid,
  output logic                  exp_ready,
  input  logic [DATA_WIDTH-1:0] exp_data,
  input  logic [DATA_WIDTH-1:0] exp_mask,
  input  logic                  act_valid,
  output logic                  act_ready,
  input  logic [DATA_WIDTH-1:0] act_data,
  input  logic                  finish,
  output logic                  done,
  output logic                  error,
  output logic                  timeout,
  output logic [CNT_WIDTH-1:0]  match_count,
  output logic [CNT_WIDTH-1:0]  mismatch_count,
  output logic [CNT_WIDTH-1:0]  unexpected_count,
  output logic [CNT_WIDTH-1:0]  first_index,
  output logic [DATA_WIDTH-1:0] first_exp,
  output logic [DATA_WIDTH-1:0] first_act
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam bit WD_EN = (TIMEOUT != 0);
  localparam int WD_W = $clog2(TIMEOUT + 2);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [DATA_WIDTH-1:0] mem_mask [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           count;
  logic                  live;
  logic                  r_pend;
  logic [CNT_WIDTH-1:0]  beat_idx;
  logic [WD_W-1:0]       wd_cnt;

  logic                  push, pop, accept, empty, mismatch, wd_fire;
  logic [DATA_WIDTH-1:0] head_mask, exp_m, act_m;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign empty     = (count == '0);
  assign exp_ready = live && (state == S_RUN) && (count < FULL);
  assign act_ready = live;
  assign push      = exp_valid && exp_ready;
  assign accept    = act_valid && act_ready;
  assign pop       = accept && !empty;
  assign done      = (state == S_DONE);

  assign head_mask = mem_mask[rd_ptr];
  assign exp_m     = mem_data[rd_ptr] & head_mask;
  assign act_m     = act_data & head_mask;
  assign mismatch  = (exp_m != act_m);

  // Watchdog counter parks at WD_LAST; timeout is sticky so refiring is harmless.
  assign wd_fire   = WD_EN && !empty && !accept && (wd_cnt == WD_LAST);

  // Storage is flushed by the pointer reset; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= exp_data;
      mem_mask[wr_ptr] <= exp_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= S_RUN;
      live             <= 1'b0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      r_pend           <= 1'b0;
      beat_idx         <= '0;
      wd_cnt           <= '0;
      error            <= 1'b0;
      timeout          <= 1'b0;
      match_count      <= '0;
      mismatch_count   <= '0;
      unexpected_count <= '0;
      first_index      <= '0;
      first_exp        <= '0;
      first_act        <= '0;
    end else begin
      state  <= state_nxt;
      live   <= 1'b1;
      r_pend <= pop;

      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase

      if (accept) beat_idx <= sat_inc(beat_idx);

      if (pop) begin
        if (mismatch) begin
          mismatch_count <= sat_inc(mismatch_count);
          error          <= 1'b1;
          if (mismatch_count == '0) begin
            first_index <= beat_idx;
            first_exp   <= exp_m;
            first_act   <= act_m;
          end
        end else begin
          match_count <= sat_inc(match_count);
        end
      end

      if (accept && empty) begin
        unexpected_count <= sat_inc(unexpected_count);
        error            <= 1'b1;
      end

      if (empty || accept)     wd_cnt <= '0;
      else if (wd_cnt != WD_LAST) wd_cnt <= wd_cnt + WD_W'(1);

      if (wd_fire) begin
        timeout <= 1'b1;
        error   <= 1'b1;
      end
    end
  end

  // Drain waits out the compare retired last cycle before declaring done.
  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN:   if (finish) state_nxt = S_DRAIN;
      S_DRAIN: if (empty && !r_pend) state_nxt = S_DONE;
      default: state_nxt = state;
    endcase
  end

endmodule

// File: tb/tb_w0rm_stream_scoreboard.sv
// Randomized and directed bench with a queue-based reference model feeding a per-cycle scoreboard monitor.
module tb_w0rm_stream_scoreboard;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int CW    = 8;
  localparam int TO    = 10;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          exp_valid = 1'b0, act_valid = 1'b0, finish = 1'b0;
  logic [DW-1:0] exp_data = '0, exp_mask = '0, act_data = '0;

  logic          exp_ready, act_ready, done, error, timeout;
  logic [CW-1:0] match_count, mismatch_count, unexpected_count, first_index;
  logic [DW-1:0] first_exp, first_act;

  logic          d0_exp_ready, d0_act_ready, d0_done, d0_error, d0_timeout;
  logic [CW-1:0] d0_match_count, d0_mismatch_count, d0_unexpected_count, d0_first_index;
  logic [DW-1:0] d0_first_exp, d0_first_act;

  always #5 clk = ~clk;

  w0rm_stream_scoreboard #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_data(exp_data), .exp_mask(exp_mask),
    .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data), .finish(finish),
    .done(done), .error(error), .timeout(timeout),
    .match_count(match_count), .mismatch_count(mismatch_count),
    .unexpected_count(unexpected_count), .first_index(first_index),
    .first_exp(first_exp), .first_act(first_act)
  );

  w0rm_stream_scoreboard #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW), .TIMEOUT(0)) dut0 (
    .clk(clk), .reset(reset),
    .exp_valid(exp_valid), .exp_ready(d0_exp_ready), .exp_data(exp_data), .exp_mask(exp_mask),
    .act_valid(act_valid), .act_ready(d0_act_ready), .act_data(act_data), .finish(finish),
    .done(d0_done), .error(d0_error), .timeout(d0_timeout),
    .match_count(d0_match_count), .mismatch_count(d0_mismatch_count),
    .unexpected_count(d0_unexpected_count), .first_index(d0_first_index),
    .first_exp(d0_first_exp), .first_act(d0_first_act)
  );

  int total = 0;
  int bad   = 0;

  function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, want, $time);
    end
  endfunction

  // Reference model: expected queue plus plain counters, evaluated once per cycle.
  typedef struct { logic [DW-1:0] d; logic [DW-1:0] m; } ent_t;
  typedef struct {
    logic er, ar, dn, err, to, err0;
    int mc, mmc, uc, fi;
    logic [DW-1:0] fe, fa;
  } rec_t;

  ent_t m_q[$];
  rec_t sb_q[$];
  bit   m_live, m_pend, m_err, m_err0, m_to;
  int   m_st;  // 0 run, 1 drain, 2 done
  int   m_mc, m_mmc, m_uc, m_bi, m_fi, m_idle;
  logic [DW-1:0] m_fe, m_fa;

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  function automatic bit m_exp_rdy();
    return m_live && (m_st == 0) && (m_q.size() < DEPTH);
  endfunction

  function automatic void m_reset();
    m_q.delete();
    m_live = 0; m_pend = 0; m_err = 0; m_err0 = 0; m_to = 0; m_st = 0;
    m_mc = 0; m_mmc = 0; m_uc = 0; m_bi = 0; m_fi = 0; m_idle = 0;
    m_fe = '0; m_fa = '0;
  endfunction

  always @(negedge clk) begin : model
    bit   ne, pu, acc;
    int   nst;
    ent_t h;
    rec_t r;
    if (reset) begin
      m_reset();
    end else begin
      ne  = (m_q.size() != 0);
      pu  = exp_valid && m_exp_rdy();
      acc = act_valid && m_live;
      if (m_st == 0 && finish) nst = 1;
      else if (m_st == 1 && !ne && !m_pend) nst = 2;
      else nst = m_st;
      m_pend = 0;
      if (acc) begin
        if (ne) begin
          h = m_q.pop_front();
          m_pend = 1;
          if (((act_data ^ h.d) & h.m) != '0) begin
            if (m_mmc == 0) begin
              m_fi = m_bi; m_fe = h.d & h.m; m_fa = act_data & h.m;
            end
            m_mmc = sat(m_mmc); m_err = 1; m_err0 = 1;
          end else begin
            m_mc = sat(m_mc);
          end
        end else begin
          m_uc = sat(m_uc); m_err = 1; m_err0 = 1;
        end
        m_bi = sat(m_bi);
      end
      if (ne && !acc) begin
        m_idle++;
        if (m_idle >= TO) begin m_to = 1; m_err = 1; end
      end else begin
        m_idle = 0;
      end
      if (pu) m_q.push_back('{exp_data, exp_mask});
      m_st   = nst;
      m_live = 1;
    end
    r.er = m_exp_rdy(); r.ar = m_live; r.dn = (m_st == 2);
    r.err = m_err; r.to = m_to; r.err0 = m_err0;
    r.mc = m_mc; r.mmc = m_mmc; r.uc = m_uc; r.fi = m_fi; r.fe = m_fe; r.fa = m_fa;
    sb_q.push_back(r);
  end

  always @(posedge clk) begin : monitor
    rec_t r;
    #2;
    if (sb_q.size() > 0) begin
      r = sb_q.pop_front();
      chk("exp_ready",        32'(exp_ready),        32'(r.er));
      chk("act_ready",        32'(act_ready),        32'(r.ar));
      chk("done",             32'(done),             32'(r.dn));
      chk("error",            32'(error),            32'(r.err));
      chk("timeout",          32'(timeout),          32'(r.to));
      chk("match_count",      32'(match_count),      r.mc);
      chk("mismatch_count",   32'(mismatch_count),   r.mmc);
      chk("unexpected_count", 32'(unexpected_count), r.uc);
      chk("first_index",      32'(first_index),      r.fi);
      chk("first_exp",        32'(first_exp),        32'(r.fe));
      chk("first_act",        32'(first_act),        32'(r.fa));
      chk("nowd_error",       32'(d0_error),         32'(r.err0));
      chk("nowd_timeout",     32'(d0_timeout),       32'd0);
      chk("nowd_match_count", 32'(d0_match_count),   r.mc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    exp_valid = 1'b0; act_valid = 1'b0; finish = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    idle_in();
    repeat (n) step();
    reset = 1'b0;
  endtask

  task automatic push(input logic [DW-1:0] d, input logic [DW-1:0] m);
    exp_valid = 1'b1; exp_data = d; exp_mask = m;
    step();
    exp_valid = 1'b0;
  endtask

  task automatic observe(input logic [DW-1:0] d, input logic fin);
    act_valid = 1'b1; act_data = d; finish = fin;
    step();
    act_valid = 1'b0; finish = 1'b0;
  endtask

  task automatic chk_reset_vals();
    chk("rst exp_ready", 32'(exp_ready), 32'd0);
    chk("rst act_ready", 32'(act_ready), 32'd0);
    chk("rst done",      32'(done),      32'd0);
    chk("rst error",     32'(error),     32'd0);
    chk("rst timeout",   32'(timeout),   32'd0);
    chk("rst match",     32'(match_count),      32'd0);
    chk("rst mismatch",  32'(mismatch_count),   32'd0);
    chk("rst unexp",     32'(unexpected_count), 32'd0);
    chk("rst first_idx", 32'(first_index), 32'd0);
    chk("rst first_exp", 32'(first_exp),   32'd0);
    chk("rst first_act", 32'(first_act),   32'd0);
  endtask

  initial begin
    // reset values and ready release timing
    do_reset(3);
    chk_reset_vals();
    step();
    chk("ready first cycle exp", 32'(exp_ready), 32'd1);
    chk("ready first cycle act", 32'(act_ready), 32'd1);

    // basic matching run with finish
    for (int i = 1; i <= 4; i++) push(DW'(i), '1);
    for (int i = 1; i <= 4; i++) observe(DW'(i), i == 1);
    chk("basic done early", 32'(done), 32'd0);
    chk("basic match", 32'(match_count), 32'd4);
    chk("basic error", 32'(error), 32'd0);
    step(); step();
    chk("basic done", 32'(done), 32'd1);

    // unexpected beat after done
    observe(16'h0077, 1'b0);
    chk("post-done unexp", 32'(unexpected_count), 32'd1);
    chk("post-done error", 32'(error), 32'd1);
    chk("post-done done",  32'(done), 32'd1);

    // masked compare, first-mismatch capture, zero mask
    do_reset(2);
    step();
    push(16'hAA00, 16'hFF00);
    push(16'hFFFF, 16'hFFFF);
    push(16'h1234, 16'h0000);
    observe(16'hAA55, 1'b0);
    observe(16'hFFFE, 1'b0);
    observe(16'hBEEF, 1'b0);
    chk("mask match",     32'(match_count), 32'd2);
    chk("mask mismatch",  32'(mismatch_count), 32'd1);
    chk("mask first_idx", 32'(first_index), 32'd1);
    chk("mask first_exp", 32'(first_exp), 32'hFFFF);
    chk("mask first_act", 32'(first_act), 32'hFFFE);
    chk("mask error",     32'(error), 32'd1);
    observe(16'h0001, 1'b0);
    chk("run unexp", 32'(unexpected_count), 32'd1);

    // reset mid-operation with handshakes in flight
    for (int i = 0; i < 3; i++) push(DW'(16'h0300 + i), '1);
    reset = 1'b1; exp_valid = 1'b1; act_valid = 1'b1; act_data = 16'h0300;
    step();
    reset = 1'b0; idle_in();
    chk_reset_vals();
    step();
    push(16'h5A5A, '1);
    observe(16'h5A5A, 1'b1);
    step(); step();
    chk("fresh done",  32'(done), 32'd1);
    chk("fresh error", 32'(error), 32'd0);
    chk("fresh match", 32'(match_count), 32'd1);

    // full FIFO backpressure
    do_reset(2);
    step();
    for (int k = 0; k < DEPTH + 2; k++) begin
      if (k == DEPTH) chk("full exp_ready", 32'(exp_ready), 32'd0);
      exp_valid = 1'b1; exp_data = DW'(16'h0100 + k); exp_mask = '1;
      step();
    end
    exp_valid = 1'b0;
    observe(16'h0100, 1'b0);
    chk("after pop exp_ready", 32'(exp_ready), 32'd1);
    for (int k = 1; k < DEPTH; k++) observe(DW'(16'h0100 + k), 1'b0);
    chk("full match", 32'(match_count), 32'(DEPTH));

    // watchdog: entry valid from the cycle after the push
    push(16'h0200, '1);
    repeat (TO - 1) step();
    chk("wd before", 32'(timeout), 32'd0);
    step();
    chk("wd fire", 32'(timeout), 32'd1);
    chk("wd error", 32'(error), 32'd1);
    chk("wd disabled", 32'(d0_timeout), 32'd0);

    // counter saturation
    do_reset(2);
    step();
    for (int i = 0; i < 260; i++) begin
      exp_valid = 1'b1; exp_data = DW'(i); exp_mask = '1;
      act_valid = (i > 0); act_data = DW'(i - 1);
      step();
    end
    exp_valid = 1'b0;
    observe(DW'(259), 1'b0);
    chk("sat match", 32'(match_count), 32'(CMAX));
    chk("sat error", 32'(error), 32'd0);

    // randomized traffic
    do_reset(2);
    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(0, 399) == 0);
      exp_valid = $urandom_range(0, 1) == 1;
      exp_data  = DW'($urandom);
      case ($urandom_range(0, 3))
        0, 1:    exp_mask = '1;
        2:       exp_mask = DW'($urandom);
        default: exp_mask = '0;
      endcase
      act_valid = ($urandom_range(0, 9) < 4);
      if (m_q.size() > 0 && $urandom_range(0, 4) != 0)
        act_data = m_q[0].d ^ ((($urandom_range(0, 3) == 0) ? DW'(1) : DW'(0)) << $urandom_range(0, DW - 1));
      else
        act_data = DW'($urandom);
      finish = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0;
    idle_in();
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
